// File: rtl/fir_bus_master.sv
// fir_bus_master: host-side initiator turning abstract commands into FIR port bytes,
// returning filtered samples or verified coefficient readback.
module fir_bus_master #(
    parameter int unsigned Y_LAT   = 2,
    parameter int unsigned CHK_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [5:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_pvalid,
    output logic       rsp_err,
    output logic [7:0] err_cnt,
    output logic [7:0] bus_out,
    output logic [1:0] sel_out,
    input  logic [7:0] filt_y,
    input  logic [7:0] filt_uio
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t          state_q, state_d;
    logic [7:0]      bus_q, bus_d, rd_q, rd_d, err_q, err_d;
    logic [1:0]      sel_q, sel_d, op_q, op_d;
    logic [5:0]      data_q, data_d, chk_q, chk_d, rb;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0][5:0] sh_q, sh_d, sh_n;
    logic            rv_q, rv_d, pv_q, pv_d, re_q, re_d, last;

    assign rb   = filt_uio[7:2];
    assign last = cnt_q == (op_q == 2'd0 ? 4'(Y_LAT) : 4'(CHK_LAT));

    // shadows as they will stand once the issued command has landed in the filter
    always_comb begin
        sh_n = sh_q;
        if (op_q == 2'd1) sh_n[0] = data_q;
        else if (op_q == 2'd2) sh_n[1] = data_q;
        else if (op_q == 2'd3 && !data_q[3]) begin
            sh_n[2] = {data_q[5:3], 3'b000};
            sh_n[3] = {3'b000, data_q[2:0]};
        end else if (op_q == 2'd3)
            sh_n = data_q[5:4] == 2'd0 ? {6'd0, 6'd0, 6'd0, 6'd1} :
                   data_q[5:4] == 2'd1 ? {4{6'd1}} :
                   data_q[5:4] == 2'd2 ? {6'd1, 6'd1, 6'd2, 6'd4} :
                                         {6'd0, 6'd0, 6'h3F, 6'd1};
    end

    always_comb begin
        state_d = state_q;
        bus_d   = {2'b01, sh_q[0]};
        sel_d   = sel_q;
        op_d    = op_q;
        data_d  = data_q;
        chk_d   = chk_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
        pv_d    = pv_q;
        re_d    = re_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = ISSUE;
                bus_d   = {cmd_op, cmd_data};
                op_d    = cmd_op;
                data_d  = cmd_data;
                sel_d   = cmd_op == 2'd0 ? sel_q :
                          cmd_op == 2'd1 ? 2'b00 :
                          cmd_op == 2'd2 ? 2'b01 :
                          cmd_data[3]    ? 2'b01 : 2'b10;
            end
            ISSUE: begin
                state_d = WAIT;
                sh_d    = sh_n;
                bus_d   = {2'b01, sh_n[0]};
                cnt_d   = 4'd1;
                chk_d   = op_q == 2'd1 ? sh_n[0] :
                          (op_q == 2'd2 || data_q[3]) ? sh_n[1] : sh_n[2];
            end
            WAIT: if (last) begin
                state_d = RESP;
                rv_d    = 1'b1;
                rd_d    = op_q == 2'd0 ? filt_y : {2'b00, rb};
                pv_d    = op_q == 2'd0 && filt_uio[1];
                re_d    = op_q != 2'd0 && rb != chk_q;
                err_d   = (op_q != 2'd0 && rb != chk_q && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
            end else cnt_d = cnt_q + 4'd1;
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                rv_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bus_q   <= 8'h41;
            sel_q   <= 2'b00;
            op_q    <= 2'b00;
            data_q  <= 6'd0;
            chk_q   <= 6'd0;
            cnt_q   <= 4'd0;
            sh_q    <= {4{6'd1}};
            rv_q    <= 1'b0;
            rd_q    <= 8'd0;
            pv_q    <= 1'b0;
            re_q    <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            pv_q    <= pv_d;
            re_q    <= re_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = state_q == IDLE;
    assign rsp_valid  = rv_q;
    assign rsp_data   = rd_q;
    assign rsp_pvalid = pv_q;
    assign rsp_err    = re_q;
    assign err_cnt    = err_q;
    assign bus_out    = bus_q;
    assign sel_out    = sel_q;
endmodule

// File: tb/tb_fir_bus_master.sv
// tb_fir_bus_master: random and directed commands against a shadow/latency reference model.
module tb_fir_bus_master;
    localparam int Y_LAT   = 2;
    localparam int CHK_LAT = 1;

    logic       clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_pvalid, rsp_err;
    logic [1:0] cmd_op, sel_out;
    logic [5:0] cmd_data;
    logic [7:0] rsp_data, err_cnt, bus_out, filt_y, filt_uio;

    fir_bus_master #(.Y_LAT(Y_LAT), .CHK_LAT(CHK_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_pvalid(rsp_pvalid), .rsp_err(rsp_err), .err_cnt(err_cnt),
        .bus_out(bus_out), .sel_out(sel_out), .filt_y(filt_y), .filt_uio(filt_uio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int mode = 1;
    logic [7:0] y_at [0:65535];
    logic [7:0] u_at [0:65535];
    logic [5:0] sh [4];
    logic [5:0] exp_chk;
    logic       wr_pend;
    logic [1:0] m_sel;
    int         m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sh = '{6'd1, 6'd1, 6'd1, 6'd1};
        m_sel = 2'd0;
        m_err = 0;
        wr_pend = 1'b0;
    endtask

    // value present on filt_* just before edge k is stored at index k
    task automatic tick();
        logic [7:0] u;
        @(posedge clk);
        edge_n++;
        #1;
        filt_y = 8'($urandom);
        u = 8'($urandom);
        if (wr_pend)
            u[7:2] = mode == 2 ? exp_chk ^ 6'h3F :
                     (mode == 1 || $urandom_range(3) != 0) ? exp_chk : u[7:2];
        filt_uio = u;
        y_at[edge_n + 1] = filt_y;
        u_at[edge_n + 1] = filt_uio;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [5:0] d, input int hold);
        int a, lat, t;
        logic [5:0] rb;
        logic [7:0] ed;
        logic       ep, ee;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        check("ready_idle", cmd_ready, 1);
        tick();
        a = edge_n;
        cmd_valid = 1'b0;
        if (op == 2'd1) m_sel = 2'd0;
        else if (op == 2'd2) m_sel = 2'd1;
        else if (op == 2'd3) m_sel = d[3] ? 2'd1 : 2'd2;
        check("cmd_byte", bus_out, {op, d});
        check("sel", sel_out, m_sel);
        check("busy_c0", cmd_ready, 0);
        case (op)
            2'd1: sh[0] = d;
            2'd2: sh[1] = d;
            2'd3: if (!d[3]) begin
                sh[2] = {d[5:3], 3'b000};
                sh[3] = {3'b000, d[2:0]};
            end else case (d[5:4])
                2'd0: sh = '{6'd1, 6'd0, 6'd0, 6'd0};
                2'd1: sh = '{6'd1, 6'd1, 6'd1, 6'd1};
                2'd2: sh = '{6'd4, 6'd2, 6'd1, 6'd1};
                default: sh = '{6'd1, 6'h3F, 6'd0, 6'd0};
            endcase
            default: ;
        endcase
        exp_chk = op == 2'd1 ? sh[0] : (op == 2'd2 || d[3]) ? sh[1] : sh[2];
        wr_pend = op != 2'd0;
        lat = op == 2'd0 ? Y_LAT : CHK_LAT;
        for (t = 0; t < 20 && !rsp_valid; t++) begin
            tick();
            check("idle_byte_wait", bus_out, {2'b01, sh[0]});
            check("busy_wait", cmd_ready, 0);
        end
        wr_pend = 1'b0;
        check("rsp_latency", edge_n, a + 1 + lat);
        if (op == 2'd0) begin
            ed = y_at[edge_n];
            ep = u_at[edge_n][1];
            ee = 1'b0;
        end else begin
            rb = u_at[edge_n][7:2];
            ed = {2'b00, rb};
            ep = 1'b0;
            ee = rb != exp_chk;
            if (ee && m_err < 255) m_err++;
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, ed);
        check("rsp_pvalid", rsp_pvalid, ep);
        check("rsp_err", rsp_err, ee);
        check("err_cnt", err_cnt, m_err);
        repeat (hold) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_data", {rsp_pvalid, rsp_err, rsp_data}, {ep, ee, ed});
            check("hold_busy", cmd_ready, 0);
            check("hold_idle_byte", bus_out, {2'b01, sh[0]});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_dropped", rsp_valid, 0);
        check("ready_again", cmd_ready, 1);
        check("idle_byte_after", bus_out, {2'b01, sh[0]});
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op = 2'd0;
        cmd_data = 6'd0;
        filt_y = 8'd0;
        filt_uio = 8'd0;
        y_at[1] = 8'd0;
        u_at[1] = 8'd0;
        model_reset();
        repeat (3) tick();
        check("rst_bus", bus_out, 8'h41);
        check("rst_ready", cmd_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_data, rsp_pvalid, rsp_err}, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_sel", sel_out, 0);
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            check("idle_bus", bus_out, 8'h41);
            check("idle_ready", cmd_ready, 1);
            check("idle_rsp", rsp_valid, 0);
        end
        mode = 1;
        do_cmd(2'd1, 6'h3F, 0);
        repeat (4) do_cmd(2'd0, 6'h3F, 0);
        do_cmd(2'd3, 6'h38, 0);
        do_cmd(2'd3, 6'h32, 0);
        for (int p = 0; p < 4; p++) do_cmd(2'd3, {2'(p), 4'b1000}, 0);
        mode = 2;
        do_cmd(2'd1, 6'd5, 0);
        check("first_mismatch", err_cnt, 1);
        mode = 1;
        do_cmd(2'd2, 6'h2A, 5);
        do_cmd(2'd0, 6'h11, 5);
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_data = 6'h22;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_bus", bus_out, 8'h41);
        check("abort_rsp", rsp_valid, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_sel", sel_out, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("post_abort_rsp", rsp_valid, 0);
            check("post_abort_bus", bus_out, 8'h41);
        end
        mode = 0;
        repeat (150) begin
            do_cmd(2'($urandom), 6'($urandom), $urandom_range(3));
            repeat ($urandom_range(2)) begin
                tick();
                check("gap_bus", bus_out, {2'b01, sh[0]});
            end
        end
        mode = 2;
        repeat (300) do_cmd(2'd1, 6'($urandom), 0);
        check("err_saturated", err_cnt, 8'hFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
